// File: rtl/icache_waysel_s1.sv
// S0->S1 stage of the icache lookup: registers the per-way tag results and
// owns the hit / miss / tag-error sequencing FSM that drives the way-select bus.
module icache_waysel_s1 #(
  parameter int NWAYS = 4,
  parameter int WAYW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_s1,
  input  logic [NWAYS-1:0] tag_match_s0,
  input  logic [NWAYS-1:0] tag_vld_s0,
  input  logic [NWAYS-1:0] tag_perr_s0,
  input  logic             tlb_cam_miss_s0,
  input  logic             cam_vld_s0,
  input  logic             fill_done,
  input  logic             inv_ack,
  output logic [NWAYS-1:0] waysel_buf_s1,
  output logic [NWAYS-1:0] alltag_err_s1,
  output logic             tlb_cam_miss_s1,
  output logic             cam_vld_s1,
  output logic             ic_hit_s1,
  output logic             ic_miss_s1,
  output logic             mhit_s1,
  output logic             inv_req,
  output logic [WAYW-1:0]  inv_way,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ERR_INV   = 2'd1,
    MISS_WAIT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [NWAYS-1:0] waysel_q, waysel_d;
  logic [NWAYS-1:0] tagerr_q, tagerr_d;
  logic [NWAYS-1:0] errmask_q, errmask_d;
  logic             tlbmiss_q, tlbmiss_d;
  logic             camvld_q, camvld_d;

  logic             qual_s;
  logic             err_any_s;
  logic             way_any_s;
  logic             way_multi_s;
  logic             miss_s;
  logic             err_take_s;
  logic             load_s;
  logic [WAYW-1:0]  inv_idx_s;
  logic [NWAYS-1:0] inv_onehot_s;

  // Index of the lowest set bit; the sweep invalidates errored ways low to high.
  function automatic logic [WAYW-1:0] lowest_idx(input logic [NWAYS-1:0] m);
    logic [WAYW-1:0] idx;
    idx = '0;
    for (int i = NWAYS - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = WAYW'(i);
      end
    end
    return idx;
  endfunction

  // Qualified lookup decode from the S1 flops.
  always_comb begin
    qual_s      = camvld_q & ~tlbmiss_q & (state_q == IDLE);
    err_any_s   = |tagerr_q;
    way_any_s   = |waysel_q;
    way_multi_s = |(waysel_q & (waysel_q - {{(NWAYS-1){1'b0}}, 1'b1}));
    miss_s      = qual_s & ~err_any_s & ~way_any_s & ~stall_s1;
    err_take_s  = qual_s & err_any_s & ~stall_s1;
    inv_idx_s   = lowest_idx(errmask_q);
    inv_onehot_s = {{(NWAYS-1){1'b0}}, 1'b1} << inv_idx_s;
  end

  // Sequencing FSM next-state and errored-way mask.
  always_comb begin
    state_d   = state_q;
    errmask_d = errmask_q;
    case (state_q)
      IDLE: begin
        if (err_take_s) begin
          state_d   = ERR_INV;
          errmask_d = tagerr_q;
        end else if (miss_s) begin
          state_d = MISS_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      ERR_INV: begin
        if (inv_ack) begin
          errmask_d = errmask_q & ~inv_onehot_s;
          // The refetch after the sweep rides the miss path without a new miss pulse.
          if (errmask_d == '0) begin
            state_d = MISS_WAIT;
          end else begin
            state_d = ERR_INV;
          end
        end else begin
          state_d = ERR_INV;
        end
      end
      MISS_WAIT: begin
        if (fill_done) begin
          state_d = IDLE;
        end else begin
          state_d = MISS_WAIT;
        end
      end
      default: begin
        state_d   = IDLE;
        errmask_d = '0;
      end
    endcase
  end

  // S1 capture: loads only while idle and staying idle; a busy FSM drops cam_vld.
  always_comb begin
    load_s    = ~stall_s1 & (state_q == IDLE) & (state_d == IDLE);
    waysel_d  = waysel_q;
    tagerr_d  = tagerr_q;
    tlbmiss_d = tlbmiss_q;
    camvld_d  = camvld_q;
    if (load_s) begin
      waysel_d  = tag_match_s0 & tag_vld_s0;
      tagerr_d  = tag_perr_s0 & tag_vld_s0;
      tlbmiss_d = tlb_cam_miss_s0;
      camvld_d  = cam_vld_s0;
    end else if (state_q != IDLE) begin
      camvld_d = 1'b0;
    end else begin
      camvld_d = camvld_q;
    end
  end

  // State and S1 registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      errmask_q <= '0;
      waysel_q  <= '0;
      tagerr_q  <= '0;
      tlbmiss_q <= 1'b0;
      camvld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      errmask_q <= errmask_d;
      waysel_q  <= waysel_d;
      tagerr_q  <= tagerr_d;
      tlbmiss_q <= tlbmiss_d;
      camvld_q  <= camvld_d;
    end
  end

  assign waysel_buf_s1   = waysel_q;
  assign alltag_err_s1   = tagerr_q;
  assign tlb_cam_miss_s1 = tlbmiss_q;
  assign cam_vld_s1      = camvld_q;
  assign ic_hit_s1       = qual_s & ~err_any_s & way_any_s;
  assign mhit_s1         = ic_hit_s1 & way_multi_s;
  assign ic_miss_s1      = miss_s;
  assign busy            = (state_q != IDLE);
  assign inv_req         = (state_q == ERR_INV);
  assign inv_way         = inv_req ? inv_idx_s : '0;

  icache_waysel_s1_chk #(.WAYW(WAYW)) u_chk (
    .clk        (clk),
    .rst        (rst),
    .inv_req    (inv_req),
    .inv_ack    (inv_ack),
    .inv_way    (inv_way),
    .busy       (busy),
    .ic_hit_s1  (ic_hit_s1),
    .ic_miss_s1 (ic_miss_s1)
  );

endmodule

// Protocol checks on the way-select outputs.
module icache_waysel_s1_chk #(
  parameter int WAYW = 2
) (
  input logic            clk,
  input logic            rst,
  input logic            inv_req,
  input logic            inv_ack,
  input logic [WAYW-1:0] inv_way,
  input logic            busy,
  input logic            ic_hit_s1,
  input logic            ic_miss_s1
);

  a_inv_busy: assert property (@(posedge clk) disable iff (rst) inv_req |-> busy);
  a_inv_hold: assert property (@(posedge clk) disable iff (rst)
    (inv_req && !inv_ack) |=> (inv_req && $stable(inv_way)));
  a_hit_miss: assert property (@(posedge clk) disable iff (rst) !(ic_hit_s1 && ic_miss_s1));
  a_miss_idle: assert property (@(posedge clk) disable iff (rst) ic_miss_s1 |-> !busy);

endmodule

// File: tb/tb_icache_waysel_s1.sv
// Directed bench for icache_waysel_s1: table of single-cycle lookups plus
// hand-written miss, tag-error sweep, stall and reset sequences.
module tb_icache_waysel_s1;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall_s1;
  logic [3:0] tag_match_s0, tag_vld_s0, tag_perr_s0;
  logic       tlb_cam_miss_s0, cam_vld_s0, fill_done, inv_ack;
  logic [3:0] waysel_buf_s1, alltag_err_s1;
  logic       tlb_cam_miss_s1, cam_vld_s1, ic_hit_s1, ic_miss_s1, mhit_s1;
  logic       inv_req, busy;
  logic [1:0] inv_way;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0] match, vld, perr;
    logic       tlb, cam;
    logic [3:0] e_way, e_err;
    logic       e_tlb, e_cam, e_hit, e_miss, e_mhit;
  } vec_t;

  vec_t vecs[8];

  icache_waysel_s1 #(.NWAYS(4), .WAYW(2)) dut (
    .clk(clk), .rst(rst), .stall_s1(stall_s1),
    .tag_match_s0(tag_match_s0), .tag_vld_s0(tag_vld_s0), .tag_perr_s0(tag_perr_s0),
    .tlb_cam_miss_s0(tlb_cam_miss_s0), .cam_vld_s0(cam_vld_s0),
    .fill_done(fill_done), .inv_ack(inv_ack),
    .waysel_buf_s1(waysel_buf_s1), .alltag_err_s1(alltag_err_s1),
    .tlb_cam_miss_s1(tlb_cam_miss_s1), .cam_vld_s1(cam_vld_s1),
    .ic_hit_s1(ic_hit_s1), .ic_miss_s1(ic_miss_s1), .mhit_s1(mhit_s1),
    .inv_req(inv_req), .inv_way(inv_way), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] m, input logic [3:0] v, input logic [3:0] p,
                       input logic t, input logic c);
    tag_match_s0    = m;
    tag_vld_s0      = v;
    tag_perr_s0     = p;
    tlb_cam_miss_s0 = t;
    cam_vld_s0      = c;
  endtask

  function automatic vec_t mkv(input logic [3:0] m, input logic [3:0] v, input logic [3:0] p,
                               input logic t, input logic c, input logic [3:0] ew,
                               input logic [3:0] ee, input logic et, input logic ec,
                               input logic eh, input logic emi, input logic emh);
    vec_t r;
    r.match = m; r.vld = v; r.perr = p; r.tlb = t; r.cam = c;
    r.e_way = ew; r.e_err = ee; r.e_tlb = et; r.e_cam = ec;
    r.e_hit = eh; r.e_miss = emi; r.e_mhit = emh;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //            match    vld      perr     tlb   cam   way      err      tlb   cam   hit   miss  mhit
    vecs[0] = mkv(4'b0100, 4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[1] = mkv(4'b0101, 4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0101, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    vecs[2] = mkv(4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[3] = mkv(4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[4] = mkv(4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[5] = mkv(4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[6] = mkv(4'b0110, 4'b0011, 4'b0110, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[7] = mkv(4'b1011, 4'b1111, 4'b0000, 1'b0, 1'b1, 4'b1011, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    rst = 1'b1; stall_s1 = 1'b0; fill_done = 1'b0; inv_ack = 1'b0;
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick(); tick();
    chk("reset waysel", 32'(waysel_buf_s1), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset inv_req", 32'(inv_req), 32'h0);
    chk("reset cam_vld", 32'(cam_vld_s1), 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].match, vecs[i].vld, vecs[i].perr, vecs[i].tlb, vecs[i].cam);
      tick();
      chk($sformatf("vec%0d waysel", i), 32'(waysel_buf_s1), 32'(vecs[i].e_way));
      chk($sformatf("vec%0d alltag_err", i), 32'(alltag_err_s1), 32'(vecs[i].e_err));
      chk($sformatf("vec%0d tlb_s1", i), 32'(tlb_cam_miss_s1), 32'(vecs[i].e_tlb));
      chk($sformatf("vec%0d cam_s1", i), 32'(cam_vld_s1), 32'(vecs[i].e_cam));
      chk($sformatf("vec%0d hit", i), 32'(ic_hit_s1), 32'(vecs[i].e_hit));
      chk($sformatf("vec%0d miss", i), 32'(ic_miss_s1), 32'(vecs[i].e_miss));
      chk($sformatf("vec%0d mhit", i), 32'(mhit_s1), 32'(vecs[i].e_mhit));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'h0);
      chk($sformatf("vec%0d inv_req", i), 32'(inv_req), 32'h0);
    end

    // Stall holds S1 and masks the miss request
    drive(4'b0001, 4'b1111, 4'b0000, 1'b0, 1'b1);
    stall_s1 = 1'b1;
    tick();
    chk("stall hold waysel", 32'(waysel_buf_s1), 32'hb);
    chk("stall hold hit", 32'(ic_hit_s1), 32'h1);
    stall_s1 = 1'b0;
    tick();
    chk("unstall load waysel", 32'(waysel_buf_s1), 32'h1);
    drive(4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b1);
    tick();
    chk("miss present", 32'(ic_miss_s1), 32'h1);
    stall_s1 = 1'b1;
    #1;
    chk("miss masked by stall", 32'(ic_miss_s1), 32'h0);
    tick();
    chk("stalled miss busy", 32'(busy), 32'h0);
    stall_s1 = 1'b0;
    #1;
    chk("miss after unstall", 32'(ic_miss_s1), 32'h1);

    // Miss then fill
    drive(4'b0010, 4'b1111, 4'b0000, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("mw%0d busy", k), 32'(busy), 32'h1);
      chk($sformatf("mw%0d miss", k), 32'(ic_miss_s1), 32'h0);
      chk($sformatf("mw%0d waysel hold", k), 32'(waysel_buf_s1), 32'h0);
      chk($sformatf("mw%0d inv_req", k), 32'(inv_req), 32'h0);
    end
    chk("mw cam_vld cleared", 32'(cam_vld_s1), 32'h0);
    fill_done = 1'b1;
    tick();
    fill_done = 1'b0;
    chk("fill busy", 32'(busy), 32'h0);
    chk("fill no reload", 32'(waysel_buf_s1), 32'h0);
    chk("fill no miss", 32'(ic_miss_s1), 32'h0);
    tick();
    chk("post fill load", 32'(waysel_buf_s1), 32'h2);
    chk("post fill hit", 32'(ic_hit_s1), 32'h1);

    // Tag error sweep over ways 1 and 3
    drive(4'b0010, 4'b1111, 4'b1010, 1'b0, 1'b1);
    tick();
    chk("err loaded", 32'(alltag_err_s1), 32'ha);
    chk("err beats hit", 32'(ic_hit_s1), 32'h0);
    chk("err no miss", 32'(ic_miss_s1), 32'h0);
    drive(4'b0001, 4'b1111, 4'b0000, 1'b0, 1'b1);
    tick();
    chk("errinv busy", 32'(busy), 32'h1);
    chk("errinv req", 32'(inv_req), 32'h1);
    chk("errinv way1", 32'(inv_way), 32'h1);
    chk("errinv s1 hold", 32'(alltag_err_s1), 32'ha);
    fill_done = 1'b1;
    tick();
    fill_done = 1'b0;
    chk("errinv fill ignored", 32'(inv_req), 32'h1);
    chk("errinv delay1 way", 32'(inv_way), 32'h1);
    tick();
    chk("errinv delay2 way", 32'(inv_way), 32'h1);
    inv_ack = 1'b1;
    tick();
    inv_ack = 1'b0;
    chk("errinv after ack1 req", 32'(inv_req), 32'h1);
    chk("errinv way3", 32'(inv_way), 32'h3);
    tick();
    chk("errinv way3 stable", 32'(inv_way), 32'h3);
    inv_ack = 1'b1;
    tick();
    inv_ack = 1'b0;
    chk("sweep done req", 32'(inv_req), 32'h0);
    chk("sweep done way", 32'(inv_way), 32'h0);
    chk("sweep done busy", 32'(busy), 32'h1);
    chk("sweep no miss", 32'(ic_miss_s1), 32'h0);
    fill_done = 1'b1;
    tick();
    fill_done = 1'b0;
    chk("refetch idle", 32'(busy), 32'h0);
    chk("refetch no hit", 32'(ic_hit_s1), 32'h0);
    tick();
    chk("refetch load", 32'(waysel_buf_s1), 32'h1);
    chk("refetch err clear", 32'(alltag_err_s1), 32'h0);
    chk("refetch hit", 32'(ic_hit_s1), 32'h1);

    // Asynchronous reset in the middle of a sweep
    drive(4'b0000, 4'b1111, 4'b0100, 1'b0, 1'b1);
    tick();
    tick();
    chk("rst pre req", 32'(inv_req), 32'h1);
    chk("rst pre way", 32'(inv_way), 32'h2);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst inv_req", 32'(inv_req), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst waysel", 32'(waysel_buf_s1), 32'h0);
    chk("rst alltag_err", 32'(alltag_err_s1), 32'h0);
    chk("rst cam_vld", 32'(cam_vld_s1), 32'h0);
    tick();
    rst = 1'b0;
    fill_done = 1'b1;
    tick();
    fill_done = 1'b0;
    chk("spurious fill busy", 32'(busy), 32'h0);
    chk("spurious fill inv_req", 32'(inv_req), 32'h0);
    chk("spurious fill miss", 32'(ic_miss_s1), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
